// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared widths, payload structs and the control bubble for the ID/EX register
package id_ex_pkg;
    localparam int ID_EX_DATA_W  = 8;
    localparam int ID_EX_RADDR_W = 5;
    localparam int ID_EX_ALUOP_W = 2;

    typedef struct packed {
        logic                     memwrite;
        logic                     memread;
        logic                     memtoreg;
        logic                     Alusrc;
        logic                     regwrite;
        logic [ID_EX_ALUOP_W-1:0] Aluop;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [ID_EX_RADDR_W-1:0] rd;
        logic [ID_EX_DATA_W-1:0]  readdata1;
        logic [ID_EX_DATA_W-1:0]  readdata2;
        logic [ID_EX_DATA_W-1:0]  imm_data;
        logic [2:0]               func_3;
        logic [6:0]               func_7;
    } id_ex_data_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry valid/ready skid buffer with registered ready, flush and sync reset
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);
    logic         main_valid, skid_valid;
    logic [W-1:0] main_data, skid_data;
    logic         accept, main_free;

    assign accept    = in_valid & in_ready;
    assign main_free = !main_valid || out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (main_free) begin
            // skid always has priority; in_ready=0 guarantees no accept collides with it
            main_valid <= skid_valid || accept;
            main_data  <= skid_valid ? skid_data : accept ? in_data : main_data;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with skid back-pressure, flush and control bubble masking
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = ID_EX_DATA_W,
    parameter int RADDR_W = ID_EX_RADDR_W,
    parameter int ALUOP_W = ID_EX_ALUOP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               memwrite_in,
    input  logic               memread_in,
    input  logic               memtoreg_in,
    input  logic               Alusrc_in,
    input  logic               regwrite_in,
    input  logic [ALUOP_W-1:0] Aluop_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0]  readdata1_in,
    input  logic [DATA_W-1:0]  readdata2_in,
    input  logic [DATA_W-1:0]  imm_data_in,
    input  logic [2:0]         func_in3,
    input  logic [6:0]         func_in7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               memwrite,
    output logic               memread,
    output logic               memtoreg,
    output logic               Alusrc,
    output logic               regwrite,
    output logic [ALUOP_W-1:0] Aluop,
    output logic [RADDR_W-1:0] rd,
    output logic [DATA_W-1:0]  readdata1,
    output logic [DATA_W-1:0]  readdata2,
    output logic [DATA_W-1:0]  imm_data,
    output logic [2:0]         func_3,
    output logic [6:0]         func_7,
    output logic [1:0]         occupancy
);
    localparam int PW = $bits(id_ex_ctrl_t) + $bits(id_ex_data_t);

    id_ex_ctrl_t   ctrl_in, ctrl_q, ctrl_out;
    id_ex_data_t   data_in, data_q;
    logic [PW-1:0] payload_q;

    assign ctrl_in = '{memwrite: memwrite_in, memread: memread_in, memtoreg: memtoreg_in,
                       Alusrc: Alusrc_in, regwrite: regwrite_in, Aluop: Aluop_in};
    assign data_in = '{rd: rd_in, readdata1: readdata1_in, readdata2: readdata2_in,
                       imm_data: imm_data_in, func_3: func_in3, func_7: func_in7};

    pipe_skid_buf #(.W(PW)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({ctrl_in, data_in}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (payload_q),
        .occupancy(occupancy)
    );

    assign {ctrl_q, data_q} = payload_q;
    // data fields may go stale when empty, but control must never leak through a bubble
    assign ctrl_out  = out_valid ? ctrl_q : CTRL_BUBBLE;
    assign memwrite  = ctrl_out.memwrite;
    assign memread   = ctrl_out.memread;
    assign memtoreg  = ctrl_out.memtoreg;
    assign Alusrc    = ctrl_out.Alusrc;
    assign regwrite  = ctrl_out.regwrite;
    assign Aluop     = ctrl_out.Aluop;
    assign rd        = data_q.rd;
    assign readdata1 = data_q.readdata1;
    assign readdata2 = data_q.readdata2;
    assign imm_data  = data_q.imm_data;
    assign func_3    = data_q.func_3;
    assign func_7    = data_q.func_7;
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the 8-bit core, with a valid/ready handshake.
- Carries decode control bits, operands, immediate, rd and funct fields from decode to execute.
- Adds stall back-pressure via a 2-entry skid buffer, plus flush/bubble insertion for branch and hazard recovery.
- Outputs are fully registered; latency is 1 cycle and throughput is 1 instruction per cycle.

Parameters:
- DATA_W, 8, width of readdata1/readdata2/imm_data.
- RADDR_W, 5, width of rd.
- ALUOP_W, 2, width of Aluop.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; registered.
- memwrite_in, memread_in, memtoreg_in, Alusrc_in, regwrite_in  in  1 each  control from CU.
- Aluop_in  in  ALUOP_W  ALU op class.
- rd_in  in  RADDR_W  destination register.
- readdata1_in, readdata2_in  in  DATA_W  register-file operands.
- imm_data_in  in  DATA_W  immediate.
- func_in3  in  3  funct3.
- func_in7  in  7  funct7.
- out_valid  out  1  execute-side instruction valid.
- out_ready  in  1  execute accepts this cycle.
- memwrite, memread, memtoreg, Alusrc, regwrite  out  1 each  registered control.
- Aluop  out  ALUOP_W  registered.
- rd  out  RADDR_W  registered.
- readdata1, readdata2, imm_data  out  DATA_W  registered.
- func_3  out  3  registered.
- func_7  out  7  registered.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage:
  - Main entry drives the outputs; skid entry holds one overflow instruction.
  - Each entry has a valid bit.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- in_ready = !skid_valid, registered. Reset value 1.
- Per cycle, with flush=0 and reset=0:
  - Main empty or draining, skid empty, accept: load main from inputs next cycle.
  - Main empty or draining, skid full: move skid to main; an accept is impossible because in_ready=0.
  - Main full and not draining, accept: load skid; in_ready falls next cycle.
  - Drain with no accept and skid empty: main valid clears.
- Ordering: instructions leave in accept order; none duplicated or lost.
- Bubble rule: whenever out_valid=0, memwrite, memread, regwrite, memtoreg, Alusrc and Aluop read 0. Data fields (rd, operands, imm, funct) may hold stale values.
- flush:
  - Highest priority after reset.
  - Next cycle: both valid bits 0, occupancy 0, in_ready 1.
  - The instruction presented in the flush cycle is dropped even if in_valid=1.
  - Control outputs read 0 from the cycle after flush.
- reset:
  - Every output is 0 except in_ready=1, including data fields, occupancy and both valid bits.
  - Reset mid-stall discards both entries.
- Simultaneous accept and drain with skid empty: main reloads with no bubble, giving full throughput.
- occupancy = main_valid + skid_valid. It never exceeds 2; skid_valid implies main_valid.

Decomposition:
- Package id_ex_pkg:
  - id_ex_ctrl_t struct {memwrite, memread, memtoreg, Alusrc, regwrite, Aluop}.
  - id_ex_data_t struct {rd, readdata1, readdata2, imm_data, func_3, func_7}, sized from the package parameters.
  - CTRL_BUBBLE constant (all zero).
- Sub-module pipe_skid_buf: a generic 2-entry valid/ready skid buffer over a packed payload. The top level packs and unpacks the structs and applies bubble masking on the control outputs.

Test Plan:
- Reset with all inputs at 1 -> outputs 0, in_ready=1, occupancy=0; after release, in_ready stays 1.
- Streaming, out_ready=1: push rd=3,5,7 with readdata1=0x11,0x22,0x33 on consecutive cycles -> same values on rd/readdata1 one cycle later each, out_valid continuous, occupancy=1.
- Stall: out_ready=0 and push A (rd=1) then B (rd=2) -> occupancy=2, in_ready=0, outputs hold A. Raise out_ready -> A, then B, no bubble; in_ready returns to 1 the cycle after A drains.
- Flush while full, with in_valid=1 C (rd=9, regwrite_in=1) -> next cycle out_valid=0, regwrite=0, memwrite=0, occupancy=0, in_ready=1; C never appears.
- Bubble masking: in_valid=0 with control inputs at 1 -> control outputs remain 0 and out_valid=0.
- Reset asserted mid-stall with occupancy=2 -> next cycle all outputs 0, occupancy=0, in_ready=1; subsequent push D (imm_data=0xA5) emerges after 1 cycle.
